// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction-fetch front end.
//   WORD_W              datapath / address width
//   FETCH_*             2-bit fetch-state encoding (IDLE/REQ/HOLD/DROP)
//   PC_STEP_DEFAULT     constant fed to the external PC-increment adder
//   RESET_PC_DEFAULT    PC loaded on reset
//   EXC_VECTOR_DEFAULT  redirect destination for a misaligned target
//   fetch_entry_t       one fetched word together with its PC+4
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] FETCH_IDLE = 2'd0;
  localparam logic [1:0] FETCH_REQ  = 2'd1;
  localparam logic [1:0] FETCH_HOLD = 2'd2;
  localparam logic [1:0] FETCH_DROP = 2'd3;

  localparam logic [WORD_W-1:0] PC_STEP_DEFAULT    = 32'd4;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [WORD_W-1:0] EXC_VECTOR_DEFAULT = 32'h0000_0180;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/pc_fetch_unit_skid_buf.sv
// ---------------------------------------------------------------------------
// fetch_skid_buf
// One-entry holding register for a word that memory returned while the
// IF/ID register was stalled.
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   load   in   capture din
//   clear  in   discard the held entry (clear wins over load)
//   din    in   {instr, pc4} from the fetch path
//   dout   out  held {instr, pc4}
// ---------------------------------------------------------------------------
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout
);

  // The entry is wiped on reset and on a redirect so that a word fetched
  // down the wrong path can never be replayed into decode later on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (clear) begin
      dout <= '0;
    end else if (load) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Instruction-fetch front end: owns the PC, drives the external increment
// adder, runs the req/ack handshake with instruction memory and feeds the
// IF/ID register, handling stall, branch and jump redirects.
// Build option: define PC_ALIGN_CHECK_EN to send misaligned redirect targets
// to EXC_VECTOR and pulse align_err_o; otherwise the low two target bits are
// simply cleared and align_err_o stays 0.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   pc_o / add_b_o / pc_inc_i        external adder: A, B and sum
//   stall_i                          IF/ID cannot accept this cycle
//   branch_taken_i, branch_target_i  branch redirect
//   jump_i, jump_target_i            jump redirect (wins over branch)
//   imem_req_o, imem_addr_o          fetch request and address
//   imem_ack_i, instr_i              memory response
//   if_valid_o, if_instr_o, if_pc4_o IF/ID register contents
//   align_err_o                      one-cycle misaligned-target pulse
// ---------------------------------------------------------------------------
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [WORD_W-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter logic [WORD_W-1:0] PC_STEP    = PC_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [WORD_W-1:0] pc_o,
  output logic [WORD_W-1:0] add_b_o,
  input  logic [WORD_W-1:0] pc_inc_i,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [WORD_W-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [WORD_W-1:0] jump_target_i,
  output logic              imem_req_o,
  output logic [WORD_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [WORD_W-1:0] instr_i,
  output logic              if_valid_o,
  output logic [WORD_W-1:0] if_instr_o,
  output logic [WORD_W-1:0] if_pc4_o,
  output logic              align_err_o
);

  logic [1:0]        state;
  logic [WORD_W-1:0] pc;
  logic              drop_pending;
  logic              redirect;
  logic [WORD_W-1:0] raw_target;
  logic [WORD_W-1:0] redirect_pc;
  logic              target_misaligned;
  logic              live_ack;
  logic              skid_load;
  fetch_entry_t      skid_din;
  fetch_entry_t      skid_q;

  // A jump outranks a branch when both arrive together.
  assign redirect   = jump_i | branch_taken_i;
  assign raw_target = jump_i ? jump_target_i : branch_target_i;

`ifdef PC_ALIGN_CHECK_EN
  // Misaligned targets are diverted to the exception vector.
  assign target_misaligned = redirect && (raw_target[1:0] != 2'b00);
  assign redirect_pc       = target_misaligned ? EXC_VECTOR : raw_target;
`else
  // Without the check the target is silently word-aligned.
  logic unused_align_bits;
  assign target_misaligned = 1'b0;
  assign redirect_pc       = {raw_target[WORD_W-1:2], 2'b00};
  assign unused_align_bits = ^{EXC_VECTOR, raw_target[1:0]};
`endif

  // The PC feeds both the adder and memory straight from the register, so
  // neither output has a combinational path from any input.
  assign pc_o        = pc;
  assign imem_addr_o = pc;
  assign add_b_o     = PC_STEP;
  assign imem_req_o  = (state == FETCH_REQ);

  // An ack answering a request abandoned by an earlier redirect is stale
  // and must never be mistaken for the current fetch.
  assign live_ack = imem_ack_i & ~drop_pending;

  // A word that arrives while decode is stalled is parked in the skid
  // buffer; any redirect throws the parked word away.
  assign skid_load = (state == FETCH_REQ) && !redirect && live_ack && stall_i;
  assign skid_din  = {instr_i, pc_inc_i};

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .clear (redirect),
    .din   (skid_din),
    .dout  (skid_q)
  );

  // Fetch sequencer. A redirect takes precedence over stall and the
  // sequential path: it loads the new PC, empties IF/ID and, if a request
  // is still in flight, remembers to swallow its ack. Otherwise REQ
  // advances the PC on every live ack, diverting to HOLD when decode is
  // stalled, and HOLD replays the parked word once the stall lifts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= FETCH_IDLE;
      pc           <= RESET_PC;
      drop_pending <= 1'b0;
      if_valid_o   <= 1'b0;
      if_instr_o   <= '0;
      if_pc4_o     <= '0;
      align_err_o  <= 1'b0;
    end else begin
      align_err_o <= target_misaligned;
      if (imem_ack_i) begin
        drop_pending <= 1'b0;
      end
      if (redirect) begin
        pc         <= redirect_pc;
        if_valid_o <= 1'b0;
        if ((state == FETCH_REQ) && !imem_ack_i) begin
          state        <= FETCH_DROP;
          drop_pending <= 1'b1;
        end else begin
          state <= FETCH_REQ;
        end
      end else begin
        case (state)
          FETCH_IDLE: begin
            state <= FETCH_REQ;
          end
          FETCH_REQ: begin
            if (live_ack) begin
              pc <= pc_inc_i;
              if (stall_i) begin
                state <= FETCH_HOLD;
              end else begin
                if_instr_o <= instr_i;
                if_pc4_o   <= pc_inc_i;
                if_valid_o <= 1'b1;
              end
            end else if (!stall_i) begin
              if_valid_o <= 1'b0;
            end
          end
          FETCH_HOLD: begin
            if (!stall_i) begin
              if_instr_o <= skid_q.instr;
              if_pc4_o   <= skid_q.pc4;
              if_valid_o <= 1'b1;
              state      <= FETCH_REQ;
            end
          end
          FETCH_DROP: begin
            if (imem_ack_i) begin
              state <= FETCH_REQ;
            end
          end
          default: begin
            state <= FETCH_IDLE;
          end
        endcase
      end
    end
  end

endmodule
